// File: rtl/window_sequencer_if.sv
// window_sequencer_if: bundles the pixel-stream side and the window/status
// side of window_sequencer so a source and a consumer can be hooked up as
// one connection.
//   master : drives frame_start, pixel_valid, pixel_in; observes all outputs
//   slave  : the sequencer's view (inputs/outputs reversed)
interface window_sequencer_if;
  logic       frame_start;
  logic       pixel_valid;
  logic [7:0] pixel_in;
  logic       data_enable;
  logic [7:0] data_in_mau;
  logic       window_valid;
  logic [9:0] center_col;
  logic [9:0] center_row;
  logic       border;
  logic       frame_done;
  logic       busy;
  logic       overrun;

  modport master (
    output frame_start, pixel_valid, pixel_in,
    input  data_enable, data_in_mau, window_valid, center_col, center_row,
           border, frame_done, busy, overrun
  );

  modport slave (
    input  frame_start, pixel_valid, pixel_in,
    output data_enable, data_in_mau, window_valid, center_col, center_row,
           border, frame_done, busy, overrun
  );
endinterface

// File: rtl/window_sequencer.sv
// window_sequencer: sequences a raster pixel stream into a 7x7 line-memory
// unit and tracks which image pixel the window is centred on.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   frame_start         : one-cycle pulse, starts a frame when idle
//   pixel_valid/pixel_in: raster pixel stream, no backpressure
//   data_enable         : registered shift strobe to the line memories
//   data_in_mau         : registered pixel for the line memories (0 on flush)
//   window_valid        : window is centred on a real pixel (2 cycles after shift)
//   center_col/row      : window centre coordinates
//   border              : window overlaps the image edge
//   frame_done          : one-cycle pulse after the last window
//   busy                : sequencer not idle
//   overrun             : sticky, frame_start seen while busy
module window_sequencer #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       pixel_valid,
  input  logic [7:0] pixel_in,
  output logic       data_enable,
  output logic [7:0] data_in_mau,
  output logic       window_valid,
  output logic [9:0] center_col,
  output logic [9:0] center_row,
  output logic       border,
  output logic       frame_done,
  output logic       busy,
  output logic       overrun
);

  localparam int LAT_I = 3*IMG_W + 3;
  localparam int N_I   = IMG_W*IMG_H;
  localparam int CW    = $clog2(N_I + LAT_I + 1);

  localparam logic [CW-1:0] LAT_M1  = CW'(LAT_I - 1);
  localparam logic [CW-1:0] N_M1    = CW'(N_I - 1);
  localparam logic [9:0]    COL_MAX = 10'(IMG_W - 1);
  localparam logic [9:0]    COL_HI  = 10'(IMG_W - 4);
  localparam logic [9:0]    ROW_HI  = 10'(IMG_H - 4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_STREAM,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t r_state, w_next;

  logic [CW-1:0] r_shift_cnt, r_in_cnt, r_flush_cnt;
  logic [9:0]    r_col, r_row;
  logic [9:0]    r_col1, r_row1;
  logic          r_wv1;
  logic          r_done_d;

  logic w_start, w_shift, w_accept, w_flush, w_win;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_start  = 1'b0;
    w_shift  = 1'b0;
    w_accept = 1'b0;
    w_flush  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (frame_start) begin
          w_start = 1'b1;
          w_next  = S_FILL;
        end
      end
      S_FILL: begin
        if (pixel_valid) begin
          w_accept = 1'b1;
          w_shift  = 1'b1;
          if (r_shift_cnt == LAT_M1) w_next = S_STREAM;
        end
      end
      S_STREAM: begin
        if (pixel_valid) begin
          w_accept = 1'b1;
          w_shift  = 1'b1;
          if (r_in_cnt == N_M1) w_next = S_FLUSH;
        end
      end
      S_FLUSH: begin
        w_shift = 1'b1;
        w_flush = 1'b1;
        if (r_flush_cnt == LAT_M1) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Every shift after the fill phase has a real centre pixel, since the
  // frame totals exactly N+LAT shifts.
  assign w_win = w_shift && (r_state != S_FILL);
  assign busy  = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift_cnt <= '0;
      r_in_cnt    <= '0;
      r_flush_cnt <= '0;
      r_col       <= '0;
      r_row       <= '0;
    end else if (w_start) begin
      r_shift_cnt <= '0;
      r_in_cnt    <= '0;
      r_flush_cnt <= '0;
      r_col       <= '0;
      r_row       <= '0;
    end else begin
      if (w_shift)  r_shift_cnt <= r_shift_cnt + 1'b1;
      if (w_accept) r_in_cnt    <= r_in_cnt + 1'b1;
      if (w_flush)  r_flush_cnt <= r_flush_cnt + 1'b1;
      if (w_win) begin
        if (r_col == COL_MAX) begin
          r_col <= '0;
          r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  // Stage 1 feeds the line memories; stage 2 publishes the centre once the
  // memories hold the shifted-in pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_enable  <= 1'b0;
      data_in_mau  <= '0;
      r_wv1        <= 1'b0;
      r_col1       <= '0;
      r_row1       <= '0;
      window_valid <= 1'b0;
      center_col   <= '0;
      center_row   <= '0;
      border       <= 1'b0;
      r_done_d     <= 1'b0;
      frame_done   <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      data_enable <= w_shift;
      if (w_shift) data_in_mau <= w_flush ? 8'h00 : pixel_in;
      r_wv1 <= w_win;
      if (w_win) begin
        r_col1 <= r_col;
        r_row1 <= r_row;
      end
      window_valid <= r_wv1;
      if (r_wv1) begin
        center_col <= r_col1;
        center_row <= r_row1;
      end
      border <= r_wv1 && ((r_col1 < 10'd3) || (r_col1 > COL_HI) ||
                          (r_row1 < 10'd3) || (r_row1 > ROW_HI));
      // Two-stage delay lands frame_done one cycle after the last window.
      r_done_d   <= (r_state == S_DONE);
      frame_done <= r_done_d;
      if (frame_start && (r_state != S_IDLE)) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_window_sequencer.sv
module tb_window_sequencer;

  localparam int W   = 8;
  localparam int H   = 8;
  localparam int LAT = 3*W + 3;
  localparam int N   = W*H;

  typedef struct {
    int cyc;
    int data;
  } de_t;

  typedef struct {
    int cyc;
    int col;
    int row;
    int brd;
  } win_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;

  window_sequencer_if bus();

  de_t  de_q[$];
  win_t win_q[$];
  int   fd_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int de_n     = 0;
  int wv_n     = 0;

  window_sequencer #(.IMG_W(W), .IMG_H(H)) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_start  (bus.frame_start),
    .pixel_valid  (bus.pixel_valid),
    .pixel_in     (bus.pixel_in),
    .data_enable  (bus.data_enable),
    .data_in_mau  (bus.data_in_mau),
    .window_valid (bus.window_valid),
    .center_col   (bus.center_col),
    .center_row   (bus.center_row),
    .border       (bus.border),
    .frame_done   (bus.frame_done),
    .busy         (bus.busy),
    .overrun      (bus.overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference model: shift s driven in the current cycle appears on
  // data_enable one cycle later and as a window two cycles later.
  task automatic push_shift(input int s, input int data);
    int c, col, row, brd;
    de_q.push_back(de_t'{cyc + 1, data});
    if (s >= LAT) begin
      c   = s - LAT;
      col = c % W;
      row = c / W;
      brd = (col < 3 || col > W-4 || row < 3 || row > H-4) ? 1 : 0;
      win_q.push_back(win_t'{cyc + 2, col, row, brd});
    end
  endtask

  task automatic drive_frame(input int gaps, input int fs_at, input int stop_at,
                             input int done_fs);
    int s, t, v;
    @(posedge clk); #1;
    bus.frame_start = 1'b1;
    bus.pixel_valid = 1'b0;
    s = 0;
    t = 0;
    while (s < N) begin
      @(posedge clk); #1;
      bus.frame_start = 1'b0;
      if (t == 0) check("busy_fill", bus.busy, 1);
      v = gaps ? ((t % 2 == 0) ? 1 : 0) : 1;
      t++;
      bus.pixel_valid = v[0];
      bus.pixel_in    = 8'($urandom);
      if (v != 0) begin
        if (s == fs_at) bus.frame_start = 1'b1;
        push_shift(s, int'(bus.pixel_in));
        if (s == stop_at) return;
        s++;
      end
    end
    for (int j = 0; j < LAT; j++) begin
      @(posedge clk); #1;
      bus.frame_start = 1'b0;
      bus.pixel_valid = gaps ? 1'($urandom) : 1'b0;
      bus.pixel_in    = 8'($urandom);
      push_shift(N + j, 0);
    end
    fd_q.push_back(cyc + 3);
    @(posedge clk); #1;
    bus.pixel_valid = 1'b0;
    bus.frame_start = done_fs[0];
    check("busy_done", bus.busy, 1);
    if (done_fs != 0) begin
      @(posedge clk); #1;
      bus.frame_start = 1'b0;
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && (de_q.size() + win_q.size() + fd_q.size()) != 0; i++)
      @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check("de_q_left",  de_q.size(),  0);
    check("win_q_left", win_q.size(), 0);
    check("fd_q_left",  fd_q.size(),  0);
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    reset = 1'b1;
    bus.pixel_valid = 1'b0;
    bus.frame_start = 1'b0;
    #1;
    check("rst_de",     bus.data_enable,  0);
    check("rst_data",   bus.data_in_mau,  0);
    check("rst_wv",     bus.window_valid, 0);
    check("rst_col",    bus.center_col,   0);
    check("rst_row",    bus.center_row,   0);
    check("rst_border", bus.border,       0);
    check("rst_fd",     bus.frame_done,   0);
    check("rst_busy",   bus.busy,         0);
    check("rst_ovr",    bus.overrun,      0);
    de_q.delete();
    win_q.delete();
    fd_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("post_rst_busy", bus.busy, 0);
  endtask

  always @(negedge clk) begin
    de_t  e;
    win_t w;
    int   f;
    if (reset) begin
      de_n = 0;
      wv_n = 0;
    end else begin
      if (bus.data_enable) begin
        de_n++;
        if (de_q.size() == 0) check("de_unexpected", bus.data_enable, 0);
        else begin
          e = de_q.pop_front();
          check("de_cycle", cyc, e.cyc);
          check("de_data", bus.data_in_mau, e.data);
        end
      end
      if (bus.window_valid) begin
        wv_n++;
        if (win_q.size() == 0) check("wv_unexpected", bus.window_valid, 0);
        else begin
          w = win_q.pop_front();
          check("wv_cycle", cyc, w.cyc);
          check("center_col", bus.center_col, w.col);
          check("center_row", bus.center_row, w.row);
          check("border", bus.border, w.brd);
        end
      end else begin
        check("border_idle", bus.border, 0);
      end
      if (bus.frame_done) begin
        if (fd_q.size() == 0) check("fd_unexpected", bus.frame_done, 0);
        else begin
          f = fd_q.pop_front();
          check("fd_cycle", cyc, f);
        end
        check("de_count", de_n, N + LAT);
        check("wv_count", wv_n, N);
        de_n = 0;
        wv_n = 0;
      end
    end
  end

  initial begin
    bus.frame_start = 1'b0;
    bus.pixel_valid = 1'b0;
    bus.pixel_in    = 8'h00;
    do_reset();

    // Pixels with no frame_start must be ignored.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.pixel_valid = 1'b1;
      bus.pixel_in    = 8'($urandom);
      check("idle_busy", bus.busy, 0);
    end
    @(posedge clk); #1;
    bus.pixel_valid = 1'b0;

    // Two back-to-back frames; the second has gaps and a frame_start in DONE.
    drive_frame(0, -1, -1, 0);
    drive_frame(1, -1, -1, 1);
    wait_drain();
    check("ovr_done_fs", bus.overrun, 1);
    check("idle_after_done_fs", bus.busy, 0);

    do_reset();

    // frame_start during STREAM is ignored but flagged.
    drive_frame(0, 45, -1, 0);
    wait_drain();
    check("ovr_stream_fs", bus.overrun, 1);
    check("idle_after_frame", bus.busy, 0);

    // Abandon a frame at accepted pixel 40, then run a clean one.
    drive_frame(0, -1, 40, 0);
    do_reset();
    repeat (5) @(posedge clk);
    #1;
    check("abandon_quiet_busy", bus.busy, 0);
    drive_frame(0, -1, -1, 0);
    wait_drain();
    check("ovr_clean", bus.overrun, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
